// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU use a shift-add datapath and DIV/DIVU use a restoring
// shift-subtract datapath. Both run on magnitudes; signs are applied in a
// final FIXUP cycle, which is also the only point where HI/LO change for
// multi-cycle ops. MTHI/MTLO write HI/LO directly from IDLE.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;
  localparam logic [1:0] S_FIXUP = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               is_div_q, is_div_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand decode: signed ops take magnitudes, unsigned ops pass raw values.
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op && a[WIDTH-1];
  assign b_neg     = signed_op && b[WIDTH-1];
  // INT_MIN negates to itself, which is exactly its unsigned magnitude.
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;

  // One shift-add step: add multiplicand to the upper half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (acc_q[0] ? a_mag_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step on {remainder, quotient}: shift left one bit,
  // trial-subtract the divisor, keep the difference only if it is non-negative.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, b_mag_q};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // Sign fixup of the finished magnitude result.
  logic               res_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, a_orig;

  assign res_neg  = sign_a_q ^ sign_b_q;
  assign prod_fix = res_neg ? -acc_q : acc_q;
  assign quo_fix  = res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign a_orig   = sign_a_q ? -a_mag_q : a_mag_q;

  // Next-state logic for the control FSM, datapath and HI/LO.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    b_zero_d = b_zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              a_mag_d  = a_abs;
              b_mag_d  = b_abs;
              sign_a_d = a_neg;
              sign_b_d = b_neg;
              is_div_d = op[1];
              b_zero_d = (b == '0);
              count_d  = '0;
              busy_d   = 1'b1;
              // Multiply keeps the multiplier in the low half; divide keeps
              // the dividend there. The upper half always starts cleared.
              acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
              state_d  = op[1] ? S_DIV : S_MUL;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        acc_d   = mul_next;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = S_FIXUP;
      end

      S_DIV: begin
        acc_d   = div_next;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = S_FIXUP;
      end

      S_FIXUP: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_zero_q) begin
          hi_d = a_orig;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation and clears HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the values from
      // before this edge, independent of statement order.
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      b_zero_q <= b_zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected HI/LO pairs are queued when
// an operation is issued and compared by a monitor whenever done pulses.
module tb_mult_div_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] sb[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference model returning {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int     q, r;
    case (o)
      OP_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return 64'(p);
      end
      OP_MULTU: return {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {32'(r), 32'(q)};
      end
      default: return {x % y, x / y};
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always begin
    @(posedge clk);
    #1;
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("result", {hi, lo}, sb.pop_front());
    end
  end

  // Issue a multi-cycle op and track latency, busy and HI/LO stability.
  // inject >= 0 drives an MTLO request on that busy cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] oa, input logic [31:0] ob,
                       input logic [63:0] exp_v, input int inject);
    int n, busy_n, chg;
    logic [31:0] hi0, lo0;
    sb.push_back(exp_v);
    @(negedge clk);
    op = o; a = oa; b = ob; start = 1'b1;
    hi0 = hi; lo0 = lo;
    @(negedge clk);
    start = 1'b0;
    n = 0; busy_n = 0; chg = 0;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      if (hi !== hi0 || lo !== lo0) chg++;
      if (n == inject) begin
        start = 1'b1; op = OP_MTLO; a = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check("latency", 64'(n), 64'd33);
    check("busy_cycles", 64'(busy_n), 64'd33);
    check("hold_hilo", 64'(chg), 64'd0);
    check("busy_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  ro;

    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, hi, lo}, {1'b0, 1'b0, 32'h0, 32'h0});
    reset = 1'b0;

    // Multiply.
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, -1);
    do_op(OP_MULT,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, -1);
    do_op(OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, -1);

    // Divide, including zero divisor and signed overflow.
    do_op(OP_DIV,  32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, -1);
    do_op(OP_DIVU, 32'h00000007, 32'h00000002, 64'h00000001_00000003, -1);
    do_op(OP_DIV,  32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, -1);
    do_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, -1);
    do_op(OP_DIVU, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, -1);
    do_op(OP_DIV,  32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF, -1);

    // Random operations against the model.
    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'h0) rb = 32'h3;
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'h3;
      do_op(ro, ra, rb, model(ro, ra, rb), -1);
    end

    // MTHI in IDLE: only HI changes, no busy or done.
    @(negedge clk);
    op = OP_MTLO; a = 32'h0BADF00D; start = 1'b1;
    @(negedge clk);
    op = OP_MTHI; a = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", {32'h0, hi}, {32'h0, 32'h12345678});
    check("mthi_lo_kept", {32'h0, lo}, {32'h0, 32'h0BADF00D});
    check("mthi_no_busy_done", {62'h0, busy, done}, 64'h0);

    // Reserved op is ignored.
    op = 3'b110; a = 32'hCAFEF00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("reserved_ignored", {busy, done, hi, lo}, {1'b0, 1'b0, 32'h12345678, 32'h0BADF00D});

    // MTLO during a busy MULT is dropped; LO takes only the product.
    do_op(OP_MULT, 32'h00000006, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF4, 5);

    // Reset mid-operation takes effect without a clock edge.
    @(negedge clk);
    op = OP_MULT; a = 32'h00001234; b = 32'h00005678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_reset", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {busy, done, hi, lo}, {1'b0, 1'b0, 32'h0, 32'h0});
    @(negedge clk);
    reset = 1'b0;
    do_op(OP_MULTU, 32'h00000003, 32'h00000005, 64'h00000000_0000000F, -1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
